osc_param_bus_arb: RTL and testbench

- Arbitrates and sequences the shared oscillator patch-parameter bus (adr / data / write / read / osc_sel / patch-send) between two requesters.
  - Requester 0: MIDI CC / real-time control path.
  - Requester 1: sysex patch load/dump engine.
- Converts single-cycle requests into properly timed bus cycles: setup, strobe, hold. The osc register file captures writes on the write falling edge and reads on the read rising edge.
- Sits between the MIDI/sysex front end and the osc/env parameter ports, in the sCLK_XVXOSC domain.

---
 rtl/osc_param_bus_arb_if.sv | 35 +++
 rtl/osc_param_bus_arb.sv | 183 ++++++++++++++++++
 tb/tb_osc_param_bus_arb.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/osc_param_bus_arb_if.sv
// Requester-side and oscillator parameter-bus signals of osc_param_bus_arb.
// slave = arbiter view, master = front end / osc register file view.
interface osc_param_bus_arb_if #(
  parameter int unsigned ADR_W  = 7,
  parameter int unsigned DATA_W = 8
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADR_W-1:0]  adr0, adr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              sel0, sel1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADR_W-1:0]  bus_adr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_wdata_oe;
  logic              bus_write;
  logic              bus_read;
  logic              bus_osc_sel;
  logic              bus_patch_send;
  logic [DATA_W-1:0] bus_rdata;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, sel0, sel1, bus_rdata,
    output ack0, ack1, rdata0, rdata1, bus_adr, bus_wdata, bus_wdata_oe,
           bus_write, bus_read, bus_osc_sel, bus_patch_send, busy
  );

  modport master (
    output req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, sel0, sel1, bus_rdata,
    input  ack0, ack1, rdata0, rdata1, bus_adr, bus_wdata, bus_wdata_oe,
           bus_write, bus_read, bus_osc_sel, bus_patch_send, busy
  );
endinterface

// File: rtl/osc_param_bus_arb.sv
// Arbitrates the osc patch-parameter bus between the CC path (0) and sysex engine (1)
// and sequences setup/strobe/hold cycles. Define OSC_ARB_FIXED_PRIO_EN for req0-first priority.
module osc_param_bus_arb #(
  parameter int unsigned ADR_W      = 7,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input logic                sCLK_XVXOSC,
  input logic                iRST_N,
  osc_param_bus_arb_if.slave bus
);
  localparam int unsigned CNT_W = 4;
  // Counters reload with length-1; a zero length is stretched to one cycle.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'((SETUP_CYC  == 0) ? 0 : SETUP_CYC  - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'((STROBE_CYC == 0) ? 0 : STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'((HOLD_CYC   == 0) ? 0 : HOLD_CYC   - 1);
  localparam logic [CNT_W-1:0] CAPT_LD   = CNT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_CAPT, S_HOLD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              oe_q, oe_d, write_q, write_d, read_q, read_d;
  logic              sel_q, sel_d, ps_q, ps_d, busy_q, busy_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              win_c;

  // Winner among pending requests (only consulted in IDLE).
`ifdef OSC_ARB_FIXED_PRIO_EN
  assign win_c = ~bus.req0;
`else
  assign win_c = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
`endif

  always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      oe_q         <= 1'b0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      sel_q        <= 1'b0;
      ps_q         <= 1'b0;
      busy_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      oe_q         <= oe_d;
      write_q      <= write_d;
      read_q       <= read_d;
      sel_q        <= sel_d;
      ps_q         <= ps_d;
      busy_q       <= busy_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
    end
  end

  // Next state and next values of the registered bus/requester outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    adr_d        = adr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    oe_d         = oe_q;
    write_d      = write_q;
    read_d       = read_q;
    sel_d        = sel_q;
    ps_d         = ps_q;
    busy_d       = busy_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_d        = win_c;
          last_grant_d = win_c;
          we_d         = win_c ? bus.we1    : bus.we0;
          adr_d        = win_c ? bus.adr1   : bus.adr0;
          wdata_d      = win_c ? bus.wdata1 : bus.wdata0;
          sel_d        = win_c ? bus.sel1   : bus.sel0;
          oe_d         = we_d;
          busy_d       = 1'b1;
          cnt_d        = SETUP_LD;
          state_d      = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          write_d = we_q;
          read_d  = ~we_q;
          cnt_d   = STROBE_LD;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          write_d = 1'b0;
          read_d  = 1'b0;
          if (we_q) begin
            cnt_d   = HOLD_LD;
            state_d = S_HOLD;
          end else begin
            ps_d    = 1'b1;
            cnt_d   = CAPT_LD;
            state_d = S_CAPT;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CAPT: begin
        if (cnt_q == '0) begin
          ps_d = 1'b0;
          if (gnt_q) rdata1_d = bus.bus_rdata;
          else       rdata0_d = bus.bus_rdata;
          cnt_d   = HOLD_LD;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          oe_d    = 1'b0;
          sel_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ack0           = ack0_q;
  assign bus.ack1           = ack1_q;
  assign bus.rdata0         = rdata0_q;
  assign bus.rdata1         = rdata1_q;
  assign bus.bus_adr        = adr_q;
  assign bus.bus_wdata      = wdata_q;
  assign bus.bus_wdata_oe   = oe_q;
  assign bus.bus_write      = write_q;
  assign bus.bus_read       = read_q;
  assign bus.bus_osc_sel    = sel_q;
  assign bus.bus_patch_send = ps_q;
  assign bus.busy           = busy_q;
endmodule

// File: tb/tb_osc_param_bus_arb.sv
// Bench for osc_param_bus_arb: directed scenarios plus randomized transactions checked
// against a transaction-level model (arbitration rule, latency formula, register-file array).
module tb_osc_param_bus_arb;
  localparam int unsigned ADR_W  = 7;
  localparam int unsigned DATA_W = 8;
  localparam int SETUP  = 2;
  localparam int STROBE = 2;
  localparam int HOLD   = 1;

  logic sCLK_XVXOSC = 1'b0;
  logic iRST_N      = 1'b0;
  always #5 sCLK_XVXOSC = ~sCLK_XVXOSC;

  osc_param_bus_arb_if #(.ADR_W(ADR_W), .DATA_W(DATA_W)) ifa ();
  osc_param_bus_arb_if #(.ADR_W(ADR_W), .DATA_W(DATA_W)) ifb ();

  osc_param_bus_arb #(.ADR_W(ADR_W), .DATA_W(DATA_W),
                      .SETUP_CYC(SETUP), .STROBE_CYC(STROBE), .HOLD_CYC(HOLD)) dut (
    .sCLK_XVXOSC(sCLK_XVXOSC), .iRST_N(iRST_N), .bus(ifa));

  osc_param_bus_arb #(.ADR_W(ADR_W), .DATA_W(DATA_W),
                      .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_fast (
    .sCLK_XVXOSC(sCLK_XVXOSC), .iRST_N(iRST_N), .bus(ifb));

  // Osc register file: captures on write falling edge, drives data while patch-send is high.
  logic [DATA_W-1:0] osc_mem [128];
  logic [DATA_W-1:0] exp_mem [128];
  assign ifa.bus_rdata = ifa.bus_patch_send ? osc_mem[ifa.bus_adr] : '0;
  assign ifb.bus_rdata = '0;
  always @(negedge ifa.bus_write) if (iRST_N) osc_mem[ifa.bus_adr] <= ifa.bus_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  int last_g  = 1;

  logic              p_we    [2];
  logic [ADR_W-1:0]  p_adr   [2];
  logic [DATA_W-1:0] p_wdata [2];
  logic              p_sel   [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit r0, input bit r1, input int last);
`ifdef OSC_ARB_FIXED_PRIO_EN
    return r0 ? 0 : 1;
`else
    if (r0 && r1) return (last == 0) ? 1 : 0;
    return r1 ? 1 : 0;
`endif
  endfunction

  // One transaction on dut; got = requester observed on ack (-1 if none).
  task automatic do_txn(input bit r0, input bit r1, input bit drop, input int abort_at,
                        input bit skip_idle, output int got);
    int w, lat, ack_c, wr_n, wr_first, rd_n, rd_first, ps_n, bad_bus, both;
    logic we, sel;
    logic [ADR_W-1:0] adr;
    logic [DATA_W-1:0] wd, rd_obs;
    got = -1;
    if (!skip_idle) begin
      @(posedge sCLK_XVXOSC); #1;
      check("idle_busy", ifa.busy, 0);
      check("ack_pulse", {ifa.ack0, ifa.ack1}, 0);
    end
    ifa.we0 = p_we[0]; ifa.adr0 = p_adr[0]; ifa.wdata0 = p_wdata[0]; ifa.sel0 = p_sel[0];
    ifa.we1 = p_we[1]; ifa.adr1 = p_adr[1]; ifa.wdata1 = p_wdata[1]; ifa.sel1 = p_sel[1];
    ifa.req0 = r0; ifa.req1 = r1;
    w = pick(r0, r1, last_g);
    last_g = w;
    we = p_we[w]; adr = p_adr[w]; wd = p_wdata[w]; sel = p_sel[w];
    lat = 1 + SETUP + STROBE + HOLD + (we ? 0 : 2);
    ack_c = 0; wr_n = 0; wr_first = 0; rd_n = 0; rd_first = 0; ps_n = 0; bad_bus = 0; both = 0;
    rd_obs = '0;
    @(posedge sCLK_XVXOSC); #1;
    check("grant_busy", ifa.busy, 1);
    for (int c = 1; c <= 40; c++) begin
      if (ifa.bus_write) begin if (wr_n == 0) wr_first = c; wr_n++; end
      if (ifa.bus_read)  begin if (rd_n == 0) rd_first = c; rd_n++; end
      if (ifa.bus_patch_send) ps_n++;
      if (ifa.bus_adr !== adr || (we && ifa.bus_wdata !== wd) ||
          (c < lat && (ifa.bus_osc_sel !== sel || ifa.bus_wdata_oe !== we))) bad_bus++;
      if (ifa.ack0 && ifa.ack1) both++;
      if (c == abort_at) begin
        check("strobe_before_rst", ifa.bus_write, 1);
        iRST_N = 1'b0;
        #1;
        check("rst_write", ifa.bus_write, 0);
        check("rst_busy", ifa.busy, 0);
        check("rst_sel", ifa.bus_osc_sel, 0);
        check("rst_no_ack", {ifa.ack0, ifa.ack1}, 0);
        last_g = 1;
        return;
      end
      if (ifa.ack0 || ifa.ack1) begin
        ack_c  = c;
        got    = ifa.ack1 ? 1 : 0;
        rd_obs = (w == 1) ? ifa.rdata1 : ifa.rdata0;
        break;
      end
      if (drop && c == 1) begin
        if (w == 0) ifa.req0 = 1'b0;
        else        ifa.req1 = 1'b0;
      end
      @(posedge sCLK_XVXOSC); #1;
    end
    check("ack_latency", ack_c, lat);
    check("ack_id", got, w);
    check("ack_both", both, 0);
    check("strobe_len", we ? wr_n : rd_n, STROBE);
    check("strobe_start", we ? wr_first : rd_first, SETUP + 1);
    check("other_strobe", we ? rd_n : wr_n, 0);
    check("patch_send_len", ps_n, we ? 0 : 2);
    check("bus_stable", bad_bus, 0);
    check("done_idle", {ifa.busy, ifa.bus_wdata_oe, ifa.bus_osc_sel}, 0);
    if (!we) check("rdata", rd_obs, exp_mem[adr]);
    else     exp_mem[adr] = wd;
    if (w == 0) ifa.req0 = 1'b0;
    else        ifa.req1 = 1'b0;
  endtask

  initial begin
    int got, exp_w, busy_n, ack_c, wr_n;
    ifa.req0 = 0; ifa.req1 = 0; ifa.we0 = 0; ifa.we1 = 0; ifa.adr0 = '0; ifa.adr1 = '0;
    ifa.wdata0 = '0; ifa.wdata1 = '0; ifa.sel0 = 0; ifa.sel1 = 0;
    ifb.req0 = 0; ifb.req1 = 0; ifb.we0 = 0; ifb.we1 = 0; ifb.adr0 = '0; ifb.adr1 = '0;
    ifb.wdata0 = '0; ifb.wdata1 = '0; ifb.sel0 = 0; ifb.sel1 = 0;
    for (int i = 0; i < 128; i++) begin
      osc_mem[i] = DATA_W'($urandom);
      exp_mem[i] = osc_mem[i];
    end
    osc_mem[6] = 8'h5A;
    exp_mem[6] = 8'h5A;

    // Reset state
    #12;
    check("rst_ctrl", {ifa.busy, ifa.ack0, ifa.ack1, ifa.bus_write, ifa.bus_read,
                       ifa.bus_wdata_oe, ifa.bus_osc_sel, ifa.bus_patch_send}, 0);
    check("rst_adr", ifa.bus_adr, 0);
    check("rst_wdata", ifa.bus_wdata, 0);
    check("rst_rdata", {ifa.rdata0, ifa.rdata1}, 0);
    @(negedge sCLK_XVXOSC);
    iRST_N = 1'b1;

    // Both requesters held for four transactions
    p_we[0] = 1; p_adr[0] = 7'h10; p_wdata[0] = 8'hA1; p_sel[0] = 0;
    p_we[1] = 1; p_adr[1] = 7'h11; p_wdata[1] = 8'hB2; p_sel[1] = 1;
    for (int i = 0; i < 4; i++) begin
      do_txn(1, 1, 0, 0, 0, got);
`ifdef OSC_ARB_FIXED_PRIO_EN
      exp_w = 0;
`else
      exp_w = i % 2;
`endif
      check("rr_seq", got, exp_w);
    end
    ifa.req0 = 0; ifa.req1 = 0;

    // Write from requester 1
    p_we[1] = 1; p_adr[1] = 7'h16; p_wdata[1] = 8'hF3; p_sel[1] = 1;
    do_txn(0, 1, 0, 0, 0, got);
    check("osc_mem_16", osc_mem[7'h16], 8'hF3);

    // Read from requester 0
    p_we[0] = 0; p_adr[0] = 7'h06; p_wdata[0] = 8'h00; p_sel[0] = 0;
    do_txn(1, 0, 0, 0, 0, got);
    check("rdata0_5a", ifa.rdata0, 8'h5A);

    // Reset during the write strobe, then re-arbitration of the still-pending request
    p_we[1] = 1; p_adr[1] = 7'h30; p_wdata[1] = 8'hC3; p_sel[1] = 1;
    do_txn(0, 1, 0, SETUP + 1, 0, got);
    @(negedge sCLK_XVXOSC);
    iRST_N = 1'b1;
    do_txn(0, 1, 0, 0, 1, got);
    check("rst_regrant", got, 1);

    // Request dropped right after grant
    p_we[0] = 1; p_adr[0] = 7'h21; p_wdata[0] = 8'h3C; p_sel[0] = 1;
    do_txn(1, 0, 1, 0, 0, got);
    busy_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge sCLK_XVXOSC); #1;
      if (ifa.busy) busy_n++;
    end
    check("drop_no_retxn", busy_n, 0);

    // Minimal timing instance: 1/1/1
    @(posedge sCLK_XVXOSC); #1;
    ifb.req0 = 1; ifb.we0 = 1; ifb.adr0 = 7'h22; ifb.wdata0 = 8'h77; ifb.sel0 = 1;
    @(posedge sCLK_XVXOSC); #1;
    ack_c = 0; wr_n = 0;
    for (int c = 1; c <= 20; c++) begin
      if (ifb.bus_write) wr_n++;
      if (ifb.ack0) begin ack_c = c; break; end
      @(posedge sCLK_XVXOSC); #1;
    end
    ifb.req0 = 0;
    check("fast_ack_latency", ack_c, 4);
    check("fast_strobe_len", wr_n, 1);

    // Randomized transactions
    for (int i = 0; i < 24; i++) begin
      int r;
      r = $urandom_range(1, 3);
      for (int k = 0; k < 2; k++) begin
        p_we[k]    = 1'($urandom_range(0, 1));
        p_adr[k]   = ADR_W'($urandom_range(0, 15));
        p_wdata[k] = DATA_W'($urandom);
        p_sel[k]   = 1'($urandom_range(0, 1));
      end
      do_txn(r[0], r[1], 0, 0, 0, got);
    end
    ifa.req0 = 0; ifa.req1 = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
